// File: rtl/stopwatch_lap_core.sv
// rtl/stopwatch_lap_core.sv - BCD mm:ss.cc stopwatch time base with lap hold
// Counts prescaled tick_in pulses while running; display can freeze on a lap capture.
module stopwatch_lap_core #(
  parameter int TICKS_PER_CSEC = 10000,
  parameter int PRESC_W        = 14
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  output logic       running,
  output logic       lap_hold,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_csec,
  output logic       wrap_p
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CSEC - 1);

  state_t             state, state_n;
  logic [PRESC_W-1:0] presc_q, presc_n;
  logic [7:0]         min_q, sec_q, csec_q;
  logic [7:0]         min_n, sec_n, csec_n;
  logic [7:0]         lap_min, lap_sec, lap_csec;
  logic [7:0]         lap_min_n, lap_sec_n, lap_csec_n;
  logic [8:0]         csec_i, sec_i, min_i;
  logic               lap_hold_n, csec_inc, wrap_n;

  // Returns {carry, next}; any digit at or beyond its limit rolls, so non-BCD never persists.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    if (v[3:0] < 4'd9)
      return {1'b0, v[7:4], v[3:0] + 4'd1};
    if (v[7:4] < tens_max)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b1, 8'h00};
  endfunction

  always_comb begin
    csec_i     = bcd_inc(csec_q, 4'd9);
    sec_i      = bcd_inc(sec_q, 4'd5);
    min_i      = bcd_inc(min_q, 4'd5);
    csec_inc   = (state == RUN) && tick_in && (presc_q == PRESC_LAST);
    state_n    = state;
    presc_n    = presc_q;
    min_n      = min_q;
    sec_n      = sec_q;
    csec_n     = csec_q;
    lap_min_n  = lap_min;
    lap_sec_n  = lap_sec;
    lap_csec_n = lap_csec;
    lap_hold_n = lap_hold;
    wrap_n     = 1'b0;

    if ((state == RUN) && tick_in)
      presc_n = csec_inc ? '0 : presc_q + 1'b1;

    if (csec_inc) begin
      csec_n = csec_i[7:0];
      if (csec_i[8]) begin
        sec_n = sec_i[7:0];
        if (sec_i[8]) begin
          min_n  = min_i[7:0];
          wrap_n = min_i[8];
        end
      end
    end

    case (state)
      IDLE: begin
        if (btn_start_stop)
          state_n = RUN;
      end
      RUN: begin
        if (btn_start_stop) begin
          state_n = PAUSE;
        end else if (btn_lap_clear) begin
          lap_hold_n = !lap_hold;
          // Capture uses the registered (pre-increment) time even on a carry edge.
          if (!lap_hold) begin
            lap_min_n  = min_q;
            lap_sec_n  = sec_q;
            lap_csec_n = csec_q;
          end
        end
      end
      PAUSE: begin
        if (btn_start_stop) begin
          state_n = RUN;
        end else if (btn_lap_clear) begin
          state_n    = IDLE;
          presc_n    = '0;
          min_n      = 8'h00;
          sec_n      = 8'h00;
          csec_n     = 8'h00;
          lap_min_n  = 8'h00;
          lap_sec_n  = 8'h00;
          lap_csec_n = 8'h00;
          lap_hold_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= IDLE;
      presc_q   <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      csec_q    <= 8'h00;
      lap_min   <= 8'h00;
      lap_sec   <= 8'h00;
      lap_csec  <= 8'h00;
      lap_hold  <= 1'b0;
      running   <= 1'b0;
      wrap_p    <= 1'b0;
      disp_min  <= 8'h00;
      disp_sec  <= 8'h00;
      disp_csec <= 8'h00;
    end else begin
      state     <= state_n;
      presc_q   <= presc_n;
      min_q     <= min_n;
      sec_q     <= sec_n;
      csec_q    <= csec_n;
      lap_min   <= lap_min_n;
      lap_sec   <= lap_sec_n;
      lap_csec  <= lap_csec_n;
      lap_hold  <= lap_hold_n;
      running   <= (state_n == RUN);
      wrap_p    <= wrap_n;
      disp_min  <= lap_hold_n ? lap_min_n  : min_n;
      disp_sec  <= lap_hold_n ? lap_sec_n  : sec_n;
      disp_csec <= lap_hold_n ? lap_csec_n : csec_n;
    end
  end

endmodule
